// File: rtl/mul_fxd_pipe_pkg.sv
// Shared types and helpers for the pipelined signed fixed-point multiplier.
// The optional saturation feature is selected with QUADRA_MUL_SAT_EN (see mul_fxd_pipe).
package mul_fxd_pipe_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  localparam int W_DFLT = 16;
  localparam int F_DFLT = 8;
  localparam int STAGES = 3;

  function automatic round_mode_e round_mode(input int round);
    return (round != 0) ? RND_HALF_UP : RND_TRUNC;
  endfunction

endpackage

// File: rtl/mul_fxd_pipe_stage.sv
// Generic valid/ready pipeline register; loads whenever empty or draining downstream,
// so bubbles collapse and a full chain still moves one item per cycle.
module mul_fxd_pipe_stage
  import mul_fxd_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_data,
  output logic          valid,
  output logic [PW-1:0] data,
  input  logic          down_ready
);

  assign up_ready = !valid || down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/mul_fxd_pipe.sv
// Three-stage signed Q(W-F).F multiplier with valid/ready streaming and optional rounding.
// Define QUADRA_MUL_SAT_EN to clamp out-of-range results and expose the ovf flag.
module mul_fxd_pipe
  import mul_fxd_pipe_pkg::*;
#(
  parameter int W     = W_DFLT,
  parameter int F     = F_DFLT,
  parameter int ROUND = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y
`ifdef QUADRA_MUL_SAT_EN
  ,
  output logic         ovf
`endif
);

  localparam int PW1 = 2 * W + 1;
  localparam int PW2 = 2 * W + 1;
`ifdef QUADRA_MUL_SAT_EN
  localparam int PW3 = W + 1;
`else
  localparam int PW3 = W;
`endif

  // Half-up rounding adds 2^(F-1) at full product width, which cannot overflow.
  localparam logic signed [2*W:0] RND_ADD =
    (round_mode(ROUND) == RND_HALF_UP) ? ({{(2*W){1'b0}}, 1'b1} << (F - 1)) : '0;

  logic           s1_up_ready, v1, s2_up_ready, v2, s3_up_ready, v3;
  logic [PW1-1:0] d1, q1;
  logic [PW2-1:0] d2, q2;
  logic [PW3-1:0] d3, q3;

  // S1: sign and magnitudes; |-2^(W-1)| is representable as an unsigned W-bit value.
  logic [W-1:0] mag_a, mag_b;
  always_comb begin
    mag_a = a[W-1] ? (~a + 1'b1) : a;
    mag_b = b[W-1] ? (~b + 1'b1) : b;
    d1    = {a[W-1] ^ b[W-1], mag_a, mag_b};
  end

  // S2: unsigned magnitude product, re-signed into 2W+1 bits.
  logic           q1_sign;
  logic [W-1:0]   q1_mag_a, q1_mag_b;
  logic [2*W-1:0] prod_u;
  always_comb begin
    {q1_sign, q1_mag_a, q1_mag_b} = q1;
    prod_u = {{W{1'b0}}, q1_mag_a} * {{W{1'b0}}, q1_mag_b};
    d2     = q1_sign ? -{1'b0, prod_u} : {1'b0, prod_u};
  end

  // S3: round, arithmetic shift, then wrap or clamp.
  logic signed [2*W:0] p_rnd, r_full;
  always_comb begin
    p_rnd  = $signed(q2) + RND_ADD;
    r_full = p_rnd >>> F;
  end

`ifdef QUADRA_MUL_SAT_EN
  logic fits;
  always_comb begin
    fits = (&r_full[2*W:W-1]) || !(|r_full[2*W:W-1]);
    if (fits)
      d3 = {1'b0, r_full[W-1:0]};
    else if (r_full[2*W])
      d3 = {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      d3 = {1'b1, 1'b0, {(W-1){1'b1}}};
  end
  assign ovf = q3[W] && out_valid;
`else
  logic unused_r_hi;
  assign unused_r_hi = ^r_full[2*W:W];
  assign d3 = r_full[W-1:0];
`endif

  mul_fxd_pipe_stage #(.PW(PW1)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (in_valid),
    .up_ready   (s1_up_ready),
    .up_data    (d1),
    .valid      (v1),
    .data       (q1),
    .down_ready (s2_up_ready)
  );

  mul_fxd_pipe_stage #(.PW(PW2)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (v1),
    .up_ready   (s2_up_ready),
    .up_data    (d2),
    .valid      (v2),
    .data       (q2),
    .down_ready (s3_up_ready)
  );

  mul_fxd_pipe_stage #(.PW(PW3)) u_s3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (v2),
    .up_ready   (s3_up_ready),
    .up_data    (d3),
    .valid      (v3),
    .data       (q3),
    .down_ready (out_ready)
  );

  assign in_ready  = s1_up_ready && !rst;
  assign out_valid = v3;
  assign y         = q3[W-1:0];

endmodule

// File: tb/tb_mul_fxd_pipe.sv
// Directed bench for mul_fxd_pipe (W=16, F=8): truncating and half-up instances share stimulus.
// Saturation expectations follow QUADRA_MUL_SAT_EN.
module tb_mul_fxd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, in_ready_r, out_valid_r;
  logic [15:0] y, y_r;
  logic        last_ovf;
`ifdef QUADRA_MUL_SAT_EN
  logic        ovf, ovf_r;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_fxd_pipe #(.W(16), .F(8), .ROUND(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef QUADRA_MUL_SAT_EN
    , .ovf(ovf)
`endif
  );

  mul_fxd_pipe #(.W(16), .F(8), .ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .a(a), .b(b), .out_valid(out_valid_r), .out_ready(out_ready), .y(y_r)
`ifdef QUADRA_MUL_SAT_EN
    , .ovf(ovf_r)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction: checks acceptance, 3-cycle latency and both rounding modes.
  task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic [15:0] exp0, input logic [15:0] exp1);
    int n;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd3);
    check({tag, "_y_trunc"}, {16'd0, y}, {16'd0, exp0});
    check({tag, "_y_round"}, {16'd0, y_r}, {16'd0, exp1});
`ifdef QUADRA_MUL_SAT_EN
    last_ovf = ovf;
`else
    last_ovf = 1'b0;
`endif
    @(negedge clk);
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [15:0] va [8] = '{16'h0180, 16'hFE80, 16'hFE80, 16'hFFFF, 16'h0001, 16'h0100, 16'h0040, 16'h0003};
  logic [15:0] vb [8] = '{16'h0200, 16'h0200, 16'hFE00, 16'h0080, 16'h0080, 16'h0100, 16'hFF00, 16'h0055};
  logic [15:0] e0 [8] = '{16'h0300, 16'hFD00, 16'h0300, 16'hFFFF, 16'h0000, 16'h0100, 16'hFFC0, 16'h0000};
  logic [15:0] e1 [8] = '{16'h0300, 16'hFD00, 16'h0300, 16'h0000, 16'h0001, 16'h0100, 16'hFFC0, 16'h0001};

  initial begin
    int sent, recv, occ, cyc;
    logic acc, drn;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {16'd0, y}, 32'd0);
`ifdef QUADRA_MUL_SAT_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;

    run_single("pos_pos", 16'h0180, 16'h0200, 16'h0300, 16'h0300);
`ifdef QUADRA_MUL_SAT_EN
    check("pos_pos_ovf", {31'd0, last_ovf}, 32'd0);
`endif
    run_single("neg_pos", 16'hFE80, 16'h0200, 16'hFD00, 16'hFD00);
    run_single("neg_neg", 16'hFE80, 16'hFE00, 16'h0300, 16'h0300);
    run_single("rnd_neg", 16'hFFFF, 16'h0080, 16'hFFFF, 16'h0000);
    run_single("rnd_pos", 16'h0001, 16'h0080, 16'h0000, 16'h0001);
`ifdef QUADRA_MUL_SAT_EN
    run_single("min_min", 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF);
    check("min_min_ovf", {31'd0, last_ovf}, 32'd1);
    run_single("max_max", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    check("max_max_ovf", {31'd0, last_ovf}, 32'd1);
`else
    run_single("min_min", 16'h8000, 16'h8000, 16'h0000, 16'h0000);
    run_single("max_max", 16'h7FFF, 16'h7FFF, 16'hFF00, 16'hFF00);
`endif

    // Back-to-back stream with out_ready pattern 1,0,0,1 and an occupancy model.
    sent = 0; recv = 0; occ = 0; cyc = 0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      a = (sent < 8) ? va[sent] : 16'h0000;
      b = (sent < 8) ? vb[sent] : 16'h0000;
      #1;
      check("strm_in_ready", {31'd0, in_ready}, {31'd0, !(occ == 3 && !out_ready)});
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        check("strm_y_trunc", {16'd0, y}, {16'd0, e0[recv]});
        check("strm_y_round", {16'd0, y_r}, {16'd0, e1[recv]});
        recv++;
      end
      if (acc) sent++;
      occ = occ + int'(acc) - int'(drn);
      cyc++;
    end
    check("strm_count", recv, 32'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("strm_no_dup", {31'd0, out_valid}, 32'd0);
    end

    // Reset with two pairs in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h0180; b = 16'h0200;
    @(negedge clk);
    a = 16'hFE80; b = 16'h0200;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_y", {16'd0, y}, 32'd0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    run_single("post_rst_first", 16'h0100, 16'h0100, 16'h0100, 16'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
